// File: rtl/pipe_ctrl_pkg.sv
// Shared constants and types for the pipeline sequencer.
package pipe_ctrl_pkg;

    // Bit positions in the stall vector, one per pipeline register.
    localparam int STG_PC    = 0;
    localparam int STG_IFID  = 1;
    localparam int STG_IDEX  = 2;
    localparam int STG_EXMEM = 3;
    localparam int STG_MEMWB = 4;
    localparam int STG_WB    = 5;

    // Stall patterns: a requesting stage freezes itself and everything upstream.
    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_EX   = 6'b001111;
    localparam logic [5:0] STALL_MEM  = 6'b011111;
    localparam logic [5:0] STALL_ALL  = 6'b111111;

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } ctrl_state_e;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Request/response bundle between the pipeline stages and the sequencer.
interface pipe_ctrl_if;

    logic        stallreq_id;
    logic        stallreq_ex;
    logic        stallreq_mem;
    logic        excp_valid;
    logic [31:0] excp_vector;
    logic        eret_valid;
    logic [31:0] epc;

    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        stall_timeout;
    logic [31:0] stall_cycles;

    // Pipeline side: raises requests, consumes control.
    modport master (
        output stallreq_id, stallreq_ex, stallreq_mem,
        output excp_valid, excp_vector, eret_valid, epc,
        input  stall, flush, new_pc, stall_timeout, stall_cycles
    );

    // Sequencer side.
    modport slave (
        input  stallreq_id, stallreq_ex, stallreq_mem,
        input  excp_valid, excp_vector, eret_valid, epc,
        output stall, flush, new_pc, stall_timeout, stall_cycles
    );

endinterface

// File: rtl/pipe_ctrl_stall_watchdog.sv
// Saturating consecutive-stall counter with a single timeout pulse per episode.
module stall_watchdog #(
    parameter int unsigned STALL_LIMIT = 1024
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_stall,
    input  logic i_flush,
    output logic o_timeout
);

    localparam logic [15:0] LIMIT = 16'(STALL_LIMIT);

    logic [15:0] r_cnt;
    logic        r_hit;
    logic        r_timeout;
    logic        w_clear;
    logic        w_at_limit;

    assign w_clear    = !i_stall || i_flush;
    assign w_at_limit = (r_cnt == LIMIT);
    assign o_timeout  = r_timeout;

    // Count stalled cycles; r_hit suppresses repeat pulses until the count clears.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt     <= '0;
            r_hit     <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_at_limit && !r_hit;
            if (w_clear) begin
                r_cnt <= '0;
                r_hit <= 1'b0;
            end else if (w_at_limit) begin
                r_hit <= 1'b1;
            end else begin
                r_cnt <= r_cnt + 16'd1;
            end
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: stall merging, exception/eret flush sequencing, watchdog.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned STALL_LIMIT  = 1024
) (
    input  logic       clk,
    input  logic       reset_n,
    pipe_ctrl_if.slave bus
);

    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

    ctrl_state_e r_state;
    ctrl_state_e w_state_nxt;
    logic [3:0]  r_flush_cnt;
    logic [3:0]  w_flush_cnt_nxt;
    logic [31:0] r_new_pc;
    logic [31:0] w_new_pc_nxt;
    logic [31:0] r_stall_cycles;
    logic [5:0]  w_stall;
    logic        w_event;
    logic        w_flush;
    logic        w_timeout;

    assign w_event = bus.excp_valid || bus.eret_valid;
    // flush comes straight off the state register, so reset drops it asynchronously.
    assign w_flush = (r_state == FLUSH);

    assign bus.stall         = w_stall;
    assign bus.flush         = w_flush;
    assign bus.new_pc        = r_new_pc;
    assign bus.stall_timeout = w_timeout;
    assign bus.stall_cycles  = r_stall_cycles;

    // FSM state, flush countdown and redirect target registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_flush_cnt <= '0;
            r_new_pc    <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_flush_cnt <= w_flush_cnt_nxt;
            r_new_pc    <= w_new_pc_nxt;
        end
    end

    // Next state, redirect latch and prioritised stall vector.
    always_comb begin
        w_state_nxt     = r_state;
        w_flush_cnt_nxt = r_flush_cnt;
        w_new_pc_nxt    = r_new_pc;
        w_stall         = STALL_NONE;
        case (r_state)
            IDLE: begin
                if (w_event) begin
                    w_state_nxt     = FLUSH;
                    w_flush_cnt_nxt = FLUSH_LOAD;
                    w_new_pc_nxt    = bus.excp_valid ? bus.excp_vector : bus.epc;
                    w_stall         = STALL_ALL;
                end else if (bus.stallreq_mem) begin
                    w_stall = STALL_MEM;
                end else if (bus.stallreq_ex) begin
                    w_stall = STALL_EX;
                end else if (bus.stallreq_id) begin
                    w_stall = STALL_ID;
                end
            end
            FLUSH: begin
                if (r_flush_cnt == 4'd0) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_flush_cnt_nxt = r_flush_cnt - 4'd1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Free-running count of cycles in which the pc register is frozen.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stall_cycles <= '0;
        end else if (w_stall[STG_PC]) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    stall_watchdog #(
        .STALL_LIMIT (STALL_LIMIT)
    ) u_watchdog (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_stall   (w_stall[STG_PC]),
        .i_flush   (w_flush),
        .o_timeout (w_timeout)
    );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: two instances (1- and 3-cycle flush, stall limit 4).
module tb_pipe_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a = 1'b0;
    logic rst_b = 1'b0;

    pipe_ctrl_if ifa ();
    pipe_ctrl_if ifb ();

    pipe_ctrl #(.FLUSH_CYCLES(1), .STALL_LIMIT(4)) u_dut_a (
        .clk(clk), .reset_n(rst_a), .bus(ifa)
    );
    pipe_ctrl #(.FLUSH_CYCLES(3), .STALL_LIMIT(4)) u_dut_b (
        .clk(clk), .reset_n(rst_b), .bus(ifb)
    );

    localparam logic [4:0] R_EXC = 5'b10000;
    localparam logic [4:0] R_ERT = 5'b01000;
    localparam logic [4:0] R_MEM = 5'b00100;
    localparam logic [4:0] R_EX  = 5'b00010;
    localparam logic [4:0] R_ID  = 5'b00001;

    localparam logic [4:0] C_ST  = 5'b00001;
    localparam logic [4:0] C_FL  = 5'b00010;
    localparam logic [4:0] C_PC  = 5'b00100;
    localparam logic [4:0] C_TO  = 5'b01000;
    localparam logic [4:0] C_CY  = 5'b10000;
    localparam logic [4:0] C_ALL = 5'b11111;

    typedef struct {
        string       tag;
        logic [4:0]  care;
        logic [5:0]  stall;
        logic        flush;
        logic [31:0] pc;
        logic        tmo;
        logic [31:0] cyc;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   total = 0;
    int   bad   = 0;

    function automatic exp_t mk(string tag, logic [4:0] care, logic [5:0] st, logic fl,
                                logic [31:0] pc, logic tmo, logic [31:0] cyc);
        exp_t e;
        e.tag = tag; e.care = care; e.stall = st; e.flush = fl;
        e.pc = pc; e.tmo = tmo; e.cyc = cyc;
        return e;
    endfunction

    task automatic chk(string tag, string fld, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s.%s: got %h want %h", tag, fld, act, exp);
        end
    endtask

    task automatic check_rec(exp_t e, logic [5:0] st, logic fl, logic [31:0] pc,
                             logic tmo, logic [31:0] cyc);
        if (e.care[0]) chk(e.tag, "stall",         32'(st),  32'(e.stall));
        if (e.care[1]) chk(e.tag, "flush",         32'(fl),  32'(e.flush));
        if (e.care[2]) chk(e.tag, "new_pc",        pc,       e.pc);
        if (e.care[3]) chk(e.tag, "stall_timeout", 32'(tmo), 32'(e.tmo));
        if (e.care[4]) chk(e.tag, "stall_cycles",  cyc,      e.cyc);
    endtask

    // Monitors: outputs are sampled on the falling edge, mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (qa.size() > 0) begin
            e = qa.pop_front();
            check_rec(e, ifa.stall, ifa.flush, ifa.new_pc, ifa.stall_timeout, ifa.stall_cycles);
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (qb.size() > 0) begin
            e = qb.pop_front();
            check_rec(e, ifb.stall, ifb.flush, ifb.new_pc, ifb.stall_timeout, ifb.stall_cycles);
        end
    end

    // One cycle of stimulus for the selected instance, plus its expected outputs.
    task automatic step(input bit sel, input logic rn, input logic [4:0] req,
                        input logic [31:0] vec, input logic [31:0] ep, input exp_t e);
        @(posedge clk);
        #1;
        if (!sel) begin
            rst_a            = rn;
            ifa.excp_valid   = req[4];
            ifa.eret_valid   = req[3];
            ifa.stallreq_mem = req[2];
            ifa.stallreq_ex  = req[1];
            ifa.stallreq_id  = req[0];
            ifa.excp_vector  = vec;
            ifa.epc          = ep;
            qa.push_back(e);
        end else begin
            rst_b            = rn;
            ifb.excp_valid   = req[4];
            ifb.eret_valid   = req[3];
            ifb.stallreq_mem = req[2];
            ifb.stallreq_ex  = req[1];
            ifb.stallreq_id  = req[0];
            ifb.excp_vector  = vec;
            ifb.epc          = ep;
            qb.push_back(e);
        end
    endtask

    initial begin
        ifa.excp_valid = 1'b0; ifa.eret_valid = 1'b0; ifa.stallreq_mem = 1'b0;
        ifa.stallreq_ex = 1'b0; ifa.stallreq_id = 1'b0; ifa.excp_vector = '0; ifa.epc = '0;
        ifb.excp_valid = 1'b0; ifb.eret_valid = 1'b0; ifb.stallreq_mem = 1'b0;
        ifb.stallreq_ex = 1'b0; ifb.stallreq_id = 1'b0; ifb.excp_vector = '0; ifb.epc = '0;

        // ---------------- instance A: FLUSH_CYCLES=1, STALL_LIMIT=4
        step(0, 0, 5'b0, 0, 0, mk("a_rst", C_ALL, 6'b0, 0, 0, 0, 0));
        step(0, 0, 5'b0, 0, 0, mk("a_rst", C_ALL, 6'b0, 0, 0, 0, 0));
        step(0, 1, 5'b0, 0, 0, mk("a_rel", C_ALL, 6'b0, 0, 0, 0, 0));

        // load-use stall for three cycles
        for (int k = 0; k < 3; k++)
            step(0, 1, R_ID, 0, 0, mk("t1_id", C_ST | C_CY, 6'b000111, 0, 0, 0, 32'(k)));
        step(0, 1, 5'b0, 0, 0, mk("t1_end", C_ST | C_FL | C_TO | C_CY, 6'b0, 0, 0, 0, 3));

        // priority among simultaneous requests
        step(0, 1, R_ID | R_EX | R_MEM, 0, 0, mk("t2_all", C_ST | C_CY, 6'b011111, 0, 0, 0, 3));
        step(0, 1, R_ID | R_EX,         0, 0, mk("t2_ex",  C_ST | C_CY, 6'b001111, 0, 0, 0, 4));
        step(0, 1, 5'b0,                0, 0, mk("t2_end", C_ST | C_TO | C_CY, 6'b0, 0, 0, 0, 5));

        // exception while EX is stalling
        step(0, 1, R_EXC | R_EX, 32'hBFC00380, 0,
             mk("t3_evt", C_ST | C_FL | C_CY, 6'b111111, 0, 0, 0, 5));
        step(0, 1, R_EX, 0, 0,
             mk("t3_fl", C_ST | C_FL | C_PC | C_CY, 6'b0, 1, 32'hBFC00380, 0, 6));
        step(0, 1, 5'b0, 0, 0,
             mk("t3_end", C_ST | C_FL | C_PC | C_CY, 6'b0, 0, 32'hBFC00380, 0, 6));

        // exception beats eret
        step(0, 1, R_EXC | R_ERT, 32'h80000180, 32'h80001000,
             mk("t4_evt", C_ST | C_FL | C_CY, 6'b111111, 0, 0, 0, 6));
        step(0, 1, 5'b0, 0, 0, mk("t4_fl", C_FL | C_PC | C_CY, 6'b0, 1, 32'h80000180, 0, 7));
        step(0, 1, 5'b0, 0, 0, mk("t4_end", C_ST | C_FL, 6'b0, 0, 0, 0, 0));

        // watchdog: 8 stalled cycles give one pulse, 5 cycles after the start
        for (int k = 0; k < 8; k++)
            step(0, 1, R_MEM, 0, 0,
                 mk("t5_wd1", C_ST | C_TO | C_CY, 6'b011111, 0, 0, (k == 5), 32'(7 + k)));
        step(0, 1, 5'b0, 0, 0, mk("t5_rel", C_ST | C_TO | C_CY, 6'b0, 0, 0, 0, 15));
        for (int k = 0; k < 5; k++)
            step(0, 1, R_MEM, 0, 0,
                 mk("t5_wd2", C_ST | C_TO | C_CY, 6'b011111, 0, 0, 0, 32'(15 + k)));
        step(0, 1, 5'b0, 0, 0, mk("t5_pulse2", C_ST | C_TO | C_CY, 6'b0, 0, 0, 1, 20));
        step(0, 1, 5'b0, 0, 0, mk("t5_after", C_TO | C_CY, 6'b0, 0, 0, 0, 20));

        // ---------------- instance B: FLUSH_CYCLES=3, STALL_LIMIT=4
        step(1, 0, 5'b0, 0, 0, mk("b_rst", C_ALL, 6'b0, 0, 0, 0, 0));
        step(1, 1, 5'b0, 0, 0, mk("b_rel", C_ALL, 6'b0, 0, 0, 0, 0));

        // eret during a 3-cycle flush neither re-latches nor extends it
        step(1, 1, R_EXC, 32'h80000180, 0,
             mk("b1_evt", C_ST | C_FL | C_CY, 6'b111111, 0, 0, 0, 0));
        for (int k = 0; k < 3; k++)
            step(1, 1, R_ERT | R_MEM, 0, 32'h80001000,
                 mk("b1_fl", C_ST | C_FL | C_PC, 6'b0, 1, 32'h80000180, 0, 0));
        step(1, 1, 5'b0, 0, 0, mk("b1_end", C_ST | C_FL | C_PC | C_CY, 6'b0, 0, 32'h80000180, 0, 1));
        step(1, 1, 5'b0, 0, 0, mk("b1_idle", C_ST | C_FL, 6'b0, 0, 0, 0, 0));

        // reset asserted during the second flush cycle
        step(1, 1, R_ERT, 0, 32'h80001000, mk("b2_evt", C_ST | C_FL, 6'b111111, 0, 0, 0, 0));
        step(1, 1, 5'b0, 0, 0, mk("b2_fl", C_FL | C_PC, 6'b0, 1, 32'h80001000, 0, 0));
        step(1, 0, 5'b0, 0, 0, mk("b2_rst", C_ALL, 6'b0, 0, 0, 0, 0));
        step(1, 1, 5'b0, 0, 0, mk("b2_rel", C_ALL, 6'b0, 0, 0, 0, 0));
        step(1, 1, 5'b0, 0, 0, mk("b2_idle", C_ALL, 6'b0, 0, 0, 0, 0));

        repeat (3) @(posedge clk);
        if (qa.size() != 0 || qb.size() != 0) begin
            bad++;
            $display("FAIL drain: pending a=%0d b=%0d want 0", qa.size(), qb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
